// File: rtl/fft_twiddle_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fft_twiddle_gen_pkg
// Purpose  : Shared definitions for the FFT twiddle generator slice.
//            - Default sizes (twiddle width, transform length, log2 length)
//            - Quadrant encoding of the top two bits of the twiddle index
//            - Phase enumeration of the 3x fast clock within one slow cycle
// Revision : 1.0 - initial release
// ============================================================================
package fft_twiddle_gen_pkg;

  localparam int TWIDDLE_WIDTH_DEF = 10;
  localparam int FFT_N_DEF         = 1024;
  localparam int NLOG2_DEF         = 10;

  localparam real PI = 3.14159265358979323846;

  // Quadrant of k: k[NLOG2-1:NLOG2-2]
  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Fast-clock phase within a slow cycle; encoding 2'd3 means idle
  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_e;

endpackage
`default_nettype wire

// File: rtl/pll_sync_ctr.sv
`default_nettype none
// ============================================================================
// Module   : pll_sync_ctr
// Purpose  : Phase counter for a fast clock that is an integer multiple
//            (RATIO) of a PLL-aligned slow clock. The edge following a slow
//            clock rising edge is phase 0; phases then count up to RATIO-1.
//            After the last phase, or before the first slow edge is seen,
//            the counter reports all-ones (idle) until the next slow edge.
// Ports    : clk_fast_i  in  fast clock
//            rst_n       in  synchronous active-low reset
//            clk_slow_i  in  slow clock, sampled as data
//            phase_o     out phase of the current fast edge
// Revision : 1.0 - initial release
// ============================================================================
module pll_sync_ctr #(
  parameter int RATIO = 3,
  parameter int CW    = $clog2(RATIO)
) (
  input  logic          clk_fast_i,
  input  logic          rst_n,
  input  logic          clk_slow_i,
  output logic [CW-1:0] phase_o
);

  logic          slow_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          slow_rise;

  assign slow_rise = clk_slow_i & ~slow_q;

  always_comb begin
    phase_o = slow_rise ? '0 : cnt_q;
    // Past the last phase, park at idle so a missing slow edge stops updates
    if (phase_o < CW'(RATIO - 1)) begin
      cnt_d = phase_o + CW'(1);
    end else begin
      cnt_d = '1;
    end
  end

  always_ff @(posedge clk_fast_i) begin
    if (!rst_n) begin
      slow_q <= 1'b0;
      cnt_q  <= '1;
    end else begin
      slow_q <= clk_slow_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/twiddle_quarter_rom.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_quarter_rom
// Purpose  : Quarter-wave cosine table, FFT_N/4+1 entries,
//            C[m] = round((2^(TWIDDLE_WIDTH-1)-1) * cos(2*pi*m/FFT_N)).
//            Contents are computed at elaboration. Entries are non-negative,
//            so only the magnitude bits are stored.
// Ports    : clk_3x_i  in  fast clock
//            rst_n     in  synchronous active-low reset
//            addr_i    in  combinational address (NLOG2-1 bits)
//            data_o    out registered table entry (TWIDDLE_WIDTH-1 bits)
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_quarter_rom
  import fft_twiddle_gen_pkg::*;
#(
  parameter int TWIDDLE_WIDTH = TWIDDLE_WIDTH_DEF,
  parameter int FFT_N         = FFT_N_DEF,
  parameter int NLOG2         = NLOG2_DEF
) (
  input  logic                     clk_3x_i,
  input  logic                     rst_n,
  input  logic [NLOG2-2:0]         addr_i,
  output logic [TWIDDLE_WIDTH-2:0] data_o
);

  localparam int  MW    = TWIDDLE_WIDTH - 1;
  localparam int  DEPTH = FFT_N / 4 + 1;
  localparam real AMP   = real'((1 << (TWIDDLE_WIDTH - 1)) - 1);
  localparam logic [NLOG2-2:0] LAST_ADDR = (NLOG2 - 1)'(FFT_N / 4);

  logic [MW-1:0] rom_tbl [DEPTH];
  logic [MW-1:0] data_q;

  for (genvar m = 0; m < DEPTH; m++) begin : g_rom
    localparam real ANG = 2.0 * PI * real'(m) / real'(FFT_N);
    // cos is non-negative over the first quadrant; +0.5 rounds to nearest
    localparam int  VAL = $rtoi(AMP * $cos(ANG) + 0.5);
    assign rom_tbl[m] = MW'(VAL);
  end

  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (addr_i <= LAST_ADDR) begin
      data_q <= rom_tbl[addr_i];
    end else begin
      data_q <= '0;
    end
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/fft_twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module   : fft_twiddle_gen
// Purpose  : Twiddle factor W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) for one
//            FFT stage, k = (ctr_i << STAGE_SHIFT) mod FFT_N. One quarter-wave
//            ROM is time-shared over the three fast phases of a slow cycle:
//              PH0: capture k/en/ctr, read C[r], publish previous result
//              PH1: latch C[r], read C[N/4 - r]
//              PH2: latch C[N/4 - r]
//            Results (and the aligned ctr/valid) appear one slow cycle after
//            capture and hold for all three fast phases.
// Ports    : clk_3x_i in  fast clock (3x clk_i), all state clocked here
//            rst_n    in  synchronous active-low reset
//            clk_i    in  slow clock, phase alignment only
//            en_i     in  sample valid
//            ctr_i    in  sample index
//            ctr_o    out index aligned with the twiddle
//            valid_o  out en_i delayed with the twiddle latency
//            w_re_o   out cos term (signed)
//            w_im_o   out -sin term (signed), +sin in the inverse build
// Macro    : FFT_TWIDDLE_INVERSE_EN - produce the conjugate twiddle (IFFT)
// Revision : 1.0 - initial release
// ============================================================================
module fft_twiddle_gen
  import fft_twiddle_gen_pkg::*;
#(
  parameter int TWIDDLE_WIDTH = TWIDDLE_WIDTH_DEF,
  parameter int FFT_N         = FFT_N_DEF,
  parameter int NLOG2         = NLOG2_DEF,
  parameter int STAGE_SHIFT   = 0
) (
  input  logic                            clk_3x_i,
  input  logic                            rst_n,
  input  logic                            clk_i,
  input  logic                            en_i,
  input  logic        [NLOG2-1:0]         ctr_i,
  output logic        [NLOG2-1:0]         ctr_o,
  output logic                            valid_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_im_o
);

  localparam int TW = TWIDDLE_WIDTH;
  localparam int MW = TWIDDLE_WIDTH - 1;
  localparam int AW = NLOG2 - 1;
  localparam int RW = NLOG2 - 2;
  localparam logic [AW-1:0] QTR_ADDR = AW'(FFT_N / 4);

  logic [1:0]     phase;
  logic [NLOG2-1:0] k;
  logic [AW-1:0]  rom_addr;
  logic [MW-1:0]  rom_data;

  logic [NLOG2-1:0] idx_q,  idx_d;
  logic [NLOG2-1:0] ctr_q,  ctr_d;
  logic             en_q,   en_d;
  logic [MW-1:0]    a_q,    a_d;
  logic [MW-1:0]    b_q,    b_d;
  logic [NLOG2-1:0] ctr_o_q, ctr_o_d;
  logic             valid_q, valid_d;
  logic signed [TW-1:0] w_re_q, w_re_d;
  logic signed [TW-1:0] w_im_q, w_im_d;

  logic signed [TW-1:0] a_s, b_s, cos_v, sin_v;

  pll_sync_ctr #(
    .RATIO (3)
  ) u_phase (
    .clk_fast_i (clk_3x_i),
    .rst_n      (rst_n),
    .clk_slow_i (clk_i),
    .phase_o    (phase)
  );

  // Shift bits above NLOG2 fall off, giving k mod FFT_N
  assign k = ctr_i << STAGE_SHIFT;

  // PH1 reads the complementary entry; every other phase reads C[r] of the
  // live index so the PH0 edge latches it without an extra cycle.
  always_comb begin
    rom_addr = {1'b0, k[RW-1:0]};
    if (phase == PH1) begin
      rom_addr = QTR_ADDR - {1'b0, idx_q[RW-1:0]};
    end
  end

  twiddle_quarter_rom #(
    .TWIDDLE_WIDTH (TWIDDLE_WIDTH),
    .FFT_N         (FFT_N),
    .NLOG2         (NLOG2)
  ) u_rom (
    .clk_3x_i (clk_3x_i),
    .rst_n    (rst_n),
    .addr_i   (rom_addr),
    .data_o   (rom_data)
  );

  // Fold the quarter-wave magnitudes into the full circle
  assign a_s = $signed({1'b0, a_q});
  assign b_s = $signed({1'b0, b_q});

  always_comb begin
    cos_v = a_s;
    sin_v = b_s;
    case (idx_q[NLOG2-1:NLOG2-2])
      QUAD_0: begin cos_v =  a_s; sin_v =  b_s; end
      QUAD_1: begin cos_v = -b_s; sin_v =  a_s; end
      QUAD_2: begin cos_v = -a_s; sin_v = -b_s; end
      default: begin cos_v =  b_s; sin_v = -a_s; end
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    ctr_d   = ctr_q;
    en_d    = en_q;
    a_d     = a_q;
    b_d     = b_q;
    ctr_o_d = ctr_o_q;
    valid_d = valid_q;
    w_re_d  = w_re_q;
    w_im_d  = w_im_q;
    case (phase)
      PH0: begin
        w_re_d  = cos_v;
`ifdef FFT_TWIDDLE_INVERSE_EN
        w_im_d  = sin_v;
`else
        w_im_d  = -sin_v;
`endif
        ctr_o_d = ctr_q;
        valid_d = en_q;
        idx_d   = k;
        ctr_d   = ctr_i;
        en_d    = en_i;
      end
      PH1: a_d = rom_data;
      PH2: b_d = rom_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      idx_q   <= '0;
      ctr_q   <= '0;
      en_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctr_o_q <= '0;
      valid_q <= 1'b0;
      w_re_q  <= '0;
      w_im_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      ctr_q   <= ctr_d;
      en_q    <= en_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctr_o_q <= ctr_o_d;
      valid_q <= valid_d;
      w_re_q  <= w_re_d;
      w_im_q  <= w_im_d;
    end
  end

  assign ctr_o   = ctr_o_q;
  assign valid_o = valid_q;
  assign w_re_o  = w_re_q;
  assign w_im_o  = w_im_q;

endmodule
`default_nettype wire
